fifo_rr_arbiter: RTL and testbench

- Round-robin read scheduler that drains NUM_CH 8-bit FIFOs onto one shared output byte stream, toward the downstream link/serializer.
- Issues at most one FIFO read strobe per cycle.
- Grants in bursts of up to BURST_LEN words per channel.
- Honours downstream PAUSE backpressure and a per-channel enable mask.

---
 rtl/fifo_rr_arbiter_pkg.sv | 17 +
 rtl/fifo_rr_arbiter_rr_pick.sv | 27 ++
 rtl/fifo_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_fifo_rr_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_arbiter_pkg.sv
// Shared types and helpers for the FIFO round-robin read scheduler and its
// sibling shared-resource schedulers.
package fifo_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int unsigned DATA_WIDTH_DEF = 8;

  // Index width for a channel count; a single channel still needs one bit.
  function automatic int unsigned ch_w(input int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// Rotating priority encoder: picks the first requester above last_grant_i,
// wrapping modulo NUM_CH.
module fifo_rr_arbiter_rr_pick #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_grant_i,
  output logic [CH_W-1:0]   sel_o,
  output logic              any_o
);

  logic [CH_W-1:0] idx;

  // Scan from farthest to nearest so the nearest requester wins by overwrite.
  always_comb begin
    sel_o = '0;
    idx   = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      idx = CH_W'((32'(last_grant_i) + i) % NUM_CH);
      if (req_i[idx]) sel_o = idx;
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/fifo_rr_arbiter.sv
// Round-robin burst scheduler draining NUM_CH FIFOs onto one registered byte
// stream, with PAUSE backpressure and a per-channel enable mask.
module fifo_rr_arbiter
  import fifo_rr_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned BURST_LEN  = 4,
  parameter int unsigned CH_W       = ch_w(NUM_CH)
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic [NUM_CH-1:0]            FIFO_EMPTY,
  input  logic [NUM_CH*DATA_WIDTH-1:0] FIFO_DATA,
  input  logic [NUM_CH-1:0]            CH_MASK,
  input  logic                         PAUSE,
  output logic [NUM_CH-1:0]            FIFO_READ,
  output logic [DATA_WIDTH-1:0]        DATA_OUT,
  output logic                         VALID_OUT,
  output logic [CH_W-1:0]              CH_OUT,
  output logic                         BUSY
);

  localparam int unsigned CntW = $clog2(BURST_LEN + 1);

  state_e                state_q, state_d;
  logic [CH_W-1:0]       grant_q, grant_d;
  logic [CH_W-1:0]       last_grant_q, last_grant_d;
  logic [CntW-1:0]       burst_cnt_q, burst_cnt_d;
  logic [NUM_CH-1:0]     eligible;
  logic [CH_W-1:0]       pick_sel, pop_ch;
  logic                  pick_any, pop;
  logic                  rd_vld_q;
  logic [CH_W-1:0]       rd_ch_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q;
  logic [CH_W-1:0]       ch_q, ch_d;

  assign eligible = CH_MASK & ~FIFO_EMPTY;

  fifo_rr_arbiter_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .req_i        (eligible),
    .last_grant_i (last_grant_q),
    .sel_o        (pick_sel),
    .any_o        (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    pop          = 1'b0;
    pop_ch       = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!PAUSE && pick_any) begin
          pop          = 1'b1;
          pop_ch       = pick_sel;
          grant_d      = pick_sel;
          last_grant_d = pick_sel;
          burst_cnt_d  = CntW'(1);
          state_d      = ST_BURST;
        end
      end
      ST_BURST: begin
        // Exit takes priority over PAUSE so a drained or masked channel frees the slot.
        if (burst_cnt_q == CntW'(BURST_LEN) || !eligible[grant_q]) begin
          state_d = ST_IDLE;
        end else if (!PAUSE) begin
          pop         = 1'b1;
          burst_cnt_d = burst_cnt_q + CntW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Gated by RESET so no FIFO is popped while reset is held.
  assign FIFO_READ = (pop && !RESET) ? (NUM_CH'(1) << pop_ch) : '0;

  always_comb begin
    data_d = data_q;
    ch_d   = ch_q;
    if (rd_vld_q) begin
      data_d = FIFO_DATA[32'(rd_ch_q) * DATA_WIDTH +: DATA_WIDTH];
      ch_d   = rd_ch_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      burst_cnt_q  <= '0;
      rd_vld_q     <= 1'b0;
      rd_ch_q      <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      ch_q         <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
      rd_vld_q     <= pop;
      rd_ch_q      <= pop_ch;
      data_q       <= data_d;
      valid_q      <= rd_vld_q;
      ch_q         <= ch_d;
    end
  end

  assign DATA_OUT  = data_q;
  assign VALID_OUT = valid_q;
  assign CH_OUT    = ch_q;
  assign BUSY      = (state_q == ST_BURST) | rd_vld_q | valid_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Directed bench for fifo_rr_arbiter: behavioural FIFOs, an output scoreboard
// loaded with the expected grant order, and a per-cycle protocol monitor.
module tb_fifo_rr_arbiter;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DW     = 8;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic [NUM_CH-1:0] fifo_empty = '1;
  logic [NUM_CH*DW-1:0] fifo_data = '0;
  logic [NUM_CH-1:0] ch_mask = '1;
  logic              pause = 1'b0;
  logic [NUM_CH-1:0] fifo_read;
  logic [DW-1:0]     data_out;
  logic              valid_out;
  logic [1:0]        ch_out;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int vcount = 0;
  int v0;
  int vp;

  logic [DW-1:0] fq [NUM_CH][$];
  logic [9:0]    sb [$];
  logic [9:0]    mon_e;
  logic          hist1 = 1'b0;
  logic          hist2 = 1'b0;

  always #5 CLK = ~CLK;

  fifo_rr_arbiter #(
    .NUM_CH     (4),
    .DATA_WIDTH (8),
    .BURST_LEN  (4),
    .CH_W       (2)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FIFO_EMPTY (fifo_empty),
    .FIFO_DATA  (fifo_data),
    .CH_MASK    (ch_mask),
    .PAUSE      (pause),
    .FIFO_READ  (fifo_read),
    .DATA_OUT   (data_out),
    .VALID_OUT  (valid_out),
    .CH_OUT     (ch_out),
    .BUSY       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // FIFO model: registered empty flag, read data valid the cycle after READ.
  always @(posedge CLK) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (fifo_read[k]) begin
        check("pop_nonempty", 32'(fq[k].size() != 0), 32'd1);
        if (fq[k].size() != 0) fifo_data[k*DW +: DW] <= fq[k].pop_front();
      end
      fifo_empty[k] <= (fq[k].size() == 0);
    end
  end

  // Monitor, sampled mid-cycle after the bench has driven its inputs.
  always @(negedge CLK) begin
    #2;
    if (RESET) begin
      hist1 = 1'b0;
      hist2 = 1'b0;
    end else begin
      if (valid_out === 1'b1) begin
        vcount++;
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check("out_ch", 32'(ch_out), 32'(mon_e[9:8]));
          check("out_data", 32'(data_out), 32'(mon_e[7:0]));
        end
      end
      check("valid_latency", 32'(valid_out), 32'(hist2));
      check("read_legal", 32'(fifo_read & ~(ch_mask & ~fifo_empty)), 32'd0);
      check("read_onehot", 32'($onehot0(fifo_read)), 32'd1);
      if (pause) check("read_paused", 32'(fifo_read), 32'd0);
      hist2 = hist1;
      hist1 = |fifo_read;
    end
  end

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    sb.delete();
    RESET = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cyc && !done; i++) begin
      @(negedge CLK);
      #3;
      done = !busy && (sb.size() == 0);
    end
    check("idle_reached", 32'(done), 32'd1);
  endtask

  task automatic sb_push(input int ch, input int data);
    sb.push_back({2'(ch), 8'(data)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, and no pops while RESET is held even with ch0 loaded.
    fq[0].push_back(8'hA1);
    fq[0].push_back(8'hA2);
    sb_push(0, 'hA1);
    sb_push(0, 'hA2);
    #3;
    check("rst_read", 32'(fifo_read), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_ch", 32'(ch_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge CLK); #1;
    check("read_in_reset", 32'(fifo_read), 32'd0);

    // Two words from ch0, 2-cycle latency.
    @(negedge CLK); RESET = 1'b0; #1;
    check("t1_pop1", 32'(fifo_read), 32'h1);
    @(negedge CLK); #1;
    check("t1_pop2", 32'(fifo_read), 32'h1);
    @(negedge CLK); #1;
    check("t1_stop", 32'(fifo_read), 32'h0);
    check("t1_valid1", 32'(valid_out), 32'd1);
    check("t1_data1", 32'(data_out), 32'hA1);
    check("t1_ch1", 32'(ch_out), 32'd0);
    @(negedge CLK); #1;
    check("t1_valid2", 32'(valid_out), 32'd1);
    check("t1_data2", 32'(data_out), 32'hA2);
    @(negedge CLK); #1;
    check("t1_valid_end", 32'(valid_out), 32'd0);
    check("t1_busy_end", 32'(busy), 32'd0);

    // All channels, 6 words each: bursts of 4 in round-robin order.
    do_reset();
    v0 = vcount;
    for (int k = 0; k < NUM_CH; k++)
      for (int j = 0; j < 6; j++) fq[k].push_back(8'(k * 16 + j));
    for (int k = 0; k < NUM_CH; k++)
      for (int j = 0; j < 4; j++) sb_push(k, k * 16 + j);
    for (int k = 0; k < NUM_CH; k++)
      for (int j = 4; j < 6; j++) sb_push(k, k * 16 + j);
    wait_idle(200);
    check("t2_count", 32'(vcount - v0), 32'd24);

    // PAUSE for 3 cycles after the 2nd pop of a ch1 burst.
    do_reset();
    v0 = vcount;
    for (int j = 0; j < 6; j++) begin
      fq[1].push_back(8'(8'hC0 + j));
      sb_push(1, 'hC0 + j);
    end
    @(negedge CLK); #1;
    check("t3_pop1", 32'(fifo_read), 32'h2);
    @(negedge CLK); #1;
    check("t3_pop2", 32'(fifo_read), 32'h2);
    vp = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      pause = 1'b1;
      #1;
      check("t3_paused_read", 32'(fifo_read), 32'h0);
      if (valid_out === 1'b1) vp++;
    end
    check("t3_inflight", 32'(vp), 32'd2);
    @(negedge CLK); pause = 1'b0; #1;
    check("t3_resume1", 32'(fifo_read), 32'h2);
    @(negedge CLK); #1;
    check("t3_resume2", 32'(fifo_read), 32'h2);
    @(negedge CLK); #1;
    check("t3_burst_end", 32'(fifo_read), 32'h0);
    wait_idle(100);
    check("t3_count", 32'(vcount - v0), 32'd6);

    // Mask ch2 off: it is skipped and the grant wraps from ch3 to ch0.
    do_reset();
    ch_mask = 4'b1011;
    for (int k = 0; k < NUM_CH; k++)
      for (int j = 0; j < 5; j++) fq[k].push_back(8'(8'h80 + k * 16 + j));
    for (int k = 0; k < NUM_CH; k++)
      if (k != 2) for (int j = 0; j < 4; j++) sb_push(k, 'h80 + k * 16 + j);
    for (int k = 0; k < NUM_CH; k++)
      if (k != 2) sb_push(k, 'h80 + k * 16 + 4);
    wait_idle(200);
    check("t4_ch2_untouched", 32'(fq[2].size()), 32'd5);
    @(negedge CLK);
    ch_mask = 4'b1111;
    for (int j = 0; j < 5; j++) sb_push(2, 'hA0 + j);
    wait_idle(100);
    check("t4_ch2_drained", 32'(fq[2].size()), 32'd0);

    // ch3 runs dry after one word; next grant scans on to ch0.
    do_reset();
    fq[3].push_back(8'hF3);
    sb_push(3, 'hF3);
    @(negedge CLK);
    fq[0].push_back(8'hF0);
    fq[1].push_back(8'hF1);
    sb_push(0, 'hF0);
    sb_push(1, 'hF1);
    #1;
    check("t5_ch3_pop", 32'(fifo_read), 32'h8);
    @(negedge CLK); #1;
    check("t5_exit", 32'(fifo_read), 32'h0);
    @(negedge CLK); #1;
    check("t5_next_ch0", 32'(fifo_read), 32'h1);
    wait_idle(100);

    // Asynchronous reset mid-burst: in-flight word dropped, priority restarts at ch0.
    @(negedge CLK);
    for (int j = 0; j < 5; j++) fq[0].push_back(8'(8'h50 + j));
    @(negedge CLK); #1;
    check("t6_pop1", 32'(fifo_read), 32'h1);
    @(negedge CLK); #3;
    RESET = 1'b1;
    sb.delete();
    #1;
    check("t6_rst_read", 32'(fifo_read), 32'h0);
    check("t6_rst_valid", 32'(valid_out), 32'd0);
    check("t6_rst_busy", 32'(busy), 32'd0);
    @(negedge CLK);
    fq[1].push_back(8'hB0);
    fq[1].push_back(8'hB1);
    @(negedge CLK);
    RESET = 1'b0;
    for (int j = 1; j < 5; j++) sb_push(0, 'h50 + j);
    sb_push(1, 'hB0);
    sb_push(1, 'hB1);
    #1;
    check("t6_first_ch0", 32'(fifo_read), 32'h1);
    wait_idle(100);
    check("t6_ch0_drained", 32'(fq[0].size()), 32'd0);
    check("t6_ch1_drained", 32'(fq[1].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
